// File: rtl/dmem_lane_ctrl.sv
// Data-memory lane controller: decodes load/store size and alignment onto four
// byte-lane BRAMs and formats load results into a registered response.
module dmem_lane_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [31:0]           REQ_WDATA,
  output logic [ADDR_WIDTH-3:0] LANE_ADDR,
  output logic [3:0]            LANE_WE,
  output logic [3:0]            LANE_RE,
  output logic [31:0]           LANE_DIN,
  input  logic [31:0]           LANE_DOUT,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [31:0]           RSP_RDATA,
  output logic                  RSP_ERR,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the response side holds RSP_VALID and its payload until RSP_READY.
  typedef enum logic [1:0] {IDLE, ACCESS, LOAD_WAIT, RESP} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        illegal;
  logic [3:0]  mask;
  logic [31:0] din_rep;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;

  assign REQ_READY = (state == IDLE) && !RST;
  assign RSP_VALID = (state == RESP);
  assign accept    = REQ_VALID && REQ_READY;
  assign dbg_state = state;

  always_comb begin
    illegal = (REQ_SIZE == 2'b11) ||
              (REQ_SIZE == 2'b01 && REQ_ADDR[0]) ||
              (REQ_SIZE == 2'b10 && REQ_ADDR[1:0] != 2'b00);
    mask    = 4'b1111;
    din_rep = REQ_WDATA;
    case (REQ_SIZE)
      2'b00: begin
        mask    = 4'b0001 << REQ_ADDR[1:0];
        din_rep = {4{REQ_WDATA[7:0]}};
      end
      2'b01: begin
        mask    = REQ_ADDR[1] ? 4'b1100 : 4'b0011;
        din_rep = {2{REQ_WDATA[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting works from the latched request; LANE_DOUT is valid in LOAD_WAIT.
  always_comb begin
    byte_sel  = LANE_DOUT[{off_q, 3'b000} +: 8];
    half_sel  = off_q[1] ? LANE_DOUT[31:16] : LANE_DOUT[15:0];
    load_data = LANE_DOUT;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = illegal ? RESP : ACCESS;
      ACCESS:    state_next = we_q ? RESP : LOAD_WAIT;
      LOAD_WAIT: state_next = RESP;
      RESP:      if (RSP_READY) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      LANE_ADDR <= '0;
      LANE_WE   <= 4'b0000;
      LANE_RE   <= 4'b0000;
      LANE_DIN  <= 32'h0;
      RSP_RDATA <= 32'h0;
      RSP_ERR   <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
    end else begin
      state   <= state_next;
      LANE_WE <= 4'b0000;
      LANE_RE <= 4'b0000;
      if (accept) begin
        we_q      <= REQ_WE;
        size_q    <= REQ_SIZE;
        uns_q     <= REQ_UNSIGNED;
        off_q     <= REQ_ADDR[1:0];
        RSP_RDATA <= 32'h0;
        RSP_ERR   <= illegal;
        // Illegal requests leave every lane output untouched.
        if (!illegal) begin
          LANE_ADDR <= REQ_ADDR[ADDR_WIDTH-1:2];
          LANE_DIN  <= din_rep;
          LANE_WE   <= REQ_WE ? mask : 4'b0000;
          LANE_RE   <= REQ_WE ? 4'b0000 : mask;
        end
      end
      if (state == LOAD_WAIT) RSP_RDATA <= load_data;
    end
  end

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Directed bench for dmem_lane_ctrl with a four-lane synchronous byte RAM model.
module tb_dmem_lane_ctrl;

  localparam int AW = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD_WAIT = 2'd2;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [AW-3:0] lane_addr;
  logic [3:0]    lane_we, lane_re;
  logic [31:0]   lane_din, lane_dout;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  logic [7:0] mem [4][64];

  dmem_lane_ctrl #(.ADDR_WIDTH(AW)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WE(req_we), .REQ_SIZE(req_size), .REQ_UNSIGNED(req_unsigned),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .LANE_ADDR(lane_addr),
    .LANE_WE(lane_we), .LANE_RE(lane_re), .LANE_DIN(lane_din),
    .LANE_DOUT(lane_dout), .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // byte-lane BRAM model: synchronous write, registered read
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) mem[k][lane_addr] <= lane_din[8*k +: 8];
      if (lane_re[k]) lane_dout[8*k +: 8] <= mem[k][lane_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request and follows it to its response (RSP_READY assumed 1).
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input int exp_lat,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [3:0] exp_we, input logic [3:0] exp_re,
                         input logic [31:0] exp_din);
    int lat;
    logic [3:0] or_we, or_re;
    logic [AW-3:0] c1_addr;
    logic [31:0] c1_din;
    @(negedge clk);
    check({tag, ":req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    exp_q.push_back(exp_rdata);
    @(posedge clk);
    lat = 0; or_we = 4'b0; or_re = 4'b0; c1_addr = '0; c1_din = 32'h0;
    while (lat < 8) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      or_we |= lane_we;
      or_re |= lane_re;
      if (lat == 1) begin c1_addr = lane_addr; c1_din = lane_din; end
      if (rsp_valid) break;
    end
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":rdata"}, rsp_rdata, exp_q.pop_front());
    check({tag, ":err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check({tag, ":lane_we"}, {28'b0, or_we}, {28'b0, exp_we});
    check({tag, ":lane_re"}, {28'b0, or_re}, {28'b0, exp_re});
    if (!exp_err) check({tag, ":lane_addr"}, {26'b0, c1_addr}, {26'b0, addr[AW-1:2]});
    if (we && !exp_err) check({tag, ":lane_din"}, c1_din, exp_din);
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] exp_rdata,
                         input logic [3:0] exp_re);
    run_req(tag, 1'b0, size, uns, addr, 32'h0, 3, exp_rdata, 1'b0, 4'b0, exp_re, 32'h0);
  endtask

  task automatic do_store(input string tag, input logic [1:0] size,
                          input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_we, input logic [31:0] exp_din);
    run_req(tag, 1'b1, size, 1'b0, addr, wdata, 2, 32'h0, 1'b0, exp_we, 4'b0, exp_din);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [1:0] size,
                        input logic [AW-1:0] addr);
    run_req(tag, we, size, 1'b0, addr, $urandom_range(0, 32'hFFFF), 1, 32'h0, 1'b1,
            4'b0, 4'b0, 32'h0);
  endtask

  initial begin
    int waited;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 64; i++) mem[k][i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst:req_ready", {31'b0, req_ready}, 32'd0);
    check("rst:rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst:lane_en", {24'b0, lane_we, lane_re}, 32'd0);
    check("rst:lane_addr", {26'b0, lane_addr}, 32'd0);
    check("rst:lane_din", lane_din, 32'h0);
    check("rst:rsp", {rsp_rdata[30:0], rsp_err}, 32'h0);
    check("rst:state", {30'b0, dbg_state}, {30'b0, S_IDLE});
    rst = 1'b0;

    do_store("sw10", SZ_W, 8'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    do_load("lw10", SZ_W, 1'b0, 8'h10, 32'hDEADBEEF, 4'b1111);
    do_load("lb13", SZ_B, 1'b0, 8'h13, 32'hFFFFFFDE, 4'b1000);
    do_load("lbu13", SZ_B, 1'b1, 8'h13, 32'h000000DE, 4'b1000);
    do_store("sh12", SZ_H, 8'h12, 32'h12348001, 4'b1100, 32'h80018001);
    do_load("lw10b", SZ_W, 1'b0, 8'h10, 32'h8001BEEF, 4'b1111);
    do_load("lh12", SZ_H, 1'b0, 8'h12, 32'hFFFF8001, 4'b1100);
    do_load("lhu10", SZ_H, 1'b1, 8'h10, 32'h0000BEEF, 4'b0011);
    do_load("lb11", SZ_B, 1'b0, 8'h11, 32'hFFFFFFBE, 4'b0010);
    do_store("sb21", SZ_B, 8'h21, 32'h0000995A, 4'b0010, 32'h5A5A5A5A);
    do_load("lbu21", SZ_B, 1'b1, 8'h21, 32'h0000005A, 4'b0010);
    do_load("lw20", SZ_W, 1'b0, 8'h20, 32'h00005A00, 4'b1111);

    do_err("sw11", 1'b1, SZ_W, 8'h11);
    do_err("lh13", 1'b0, SZ_H, 8'h13);
    do_err("sx10", 1'b1, SZ_X, 8'h10);
    do_err("sh11", 1'b1, SZ_H, 8'h11);
    do_load("lw10c", SZ_W, 1'b0, 8'h10, 32'h8001BEEF, 4'b1111);

    // backpressure: hold the response and offer a competing store
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 8'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 8) begin @(negedge clk); waited++; end
    check("bp:valid_seen", {31'b0, rsp_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 8'h10;
      req_wdata = 32'hFFFFFFFF;
      @(negedge clk);
      check("bp:rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp:rsp_rdata", rsp_rdata, 32'h8001BEEF);
      check("bp:req_ready", {31'b0, req_ready}, 32'd0);
      check("bp:lane_we", {28'b0, lane_we}, 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("bp:idle", {30'b0, dbg_state}, {30'b0, S_IDLE});
    check("bp:released", {30'b0, rsp_valid, req_ready}, 32'd1);
    do_load("lw10d", SZ_W, 1'b0, 8'h10, 32'h8001BEEF, 4'b1111);

    // reset during LOAD_WAIT
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 8'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rml:state", {30'b0, dbg_state}, {30'b0, S_LOAD_WAIT});
    rst = 1'b1;
    @(negedge clk);
    check("rml:rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rml:lane_en", {24'b0, lane_we, lane_re}, 32'd0);
    check("rml:req_ready_rst", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rml:req_ready", {31'b0, req_ready}, 32'd1);
    do_load("rml:lbu13", SZ_B, 1'b1, 8'h13, 32'h00000080, 4'b1000);
    do_load("rml:lw10", SZ_W, 1'b0, 8'h10, 32'h8001BEEF, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_lane_ctrl.md
# dmem_lane_ctrl

Data-memory lane controller between the core's MEM stage and the four byte-lane data BRAMs (lanes 0..3, one synchronous-read byte RAM each). It accepts one load/store request per handshake. It decodes size and alignment, drives per-lane address, write enable, read enable and byte data. For loads it extracts and sign/zero-extends the addressed bytes from the lane outputs into a registered 32-bit response. Misaligned or illegal-size requests are answered with an error and never touch the RAMs.

## Interface
- ADDR_WIDTH, 8: byte-address width. The lane word index is REQ_ADDR[ADDR_WIDTH-1:2], which is ADDR_WIDTH-2 bits.
- CLK  in  1  single clock; all state on posedge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  = 1 only in IDLE and RST=0.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ_UNSIGNED  in  1  zero-extend loads (LBU/LHU); ignored for word and stores.
- REQ_ADDR  in  ADDR_WIDTH  byte address.
- REQ_WDATA  in  32  store data, right-aligned.
- LANE_ADDR  out  ADDR_WIDTH-2  word index, shared as read and write address of all lanes.
- LANE_WE  out  4  per-lane write enable, bit k = lane k.
- LANE_RE  out  4  per-lane read enable.
- LANE_DIN  out  32  lane k data = bits [8k+7:8k].
- LANE_DOUT  in  32  lane k registered read data = bits [8k+7:8k]; valid one cycle after LANE_RE.
- RSP_VALID  out  1  response valid; held until accepted.
- RSP_READY  in  1  consumer accepts.
- RSP_RDATA  out  32  load result; 0 for stores and errors.
- RSP_ERR  out  1  misaligned or illegal size.

## Operation
- FSM states: IDLE, ACCESS, LOAD_WAIT, RESP.
- **IDLE.** On REQ_VALID & REQ_READY, latch the request.
  - If the request is legal: go to ACCESS.
  - If illegal: go to RESP with RSP_ERR=1.
  - Illegal means size 11, half with addr[0]=1, or word with addr[1:0]≠0.
- **ACCESS** (one cycle). Registered lane outputs are asserted this cycle only.
  - Store: next state is RESP.
  - Load: next state is LOAD_WAIT.
- **LOAD_WAIT** (one cycle). LANE_DOUT is valid. The formatted result is registered into RSP_RDATA at the end of the cycle; next state is RESP.
- **RESP.** RSP_VALID=1. On RSP_READY, go to IDLE. RSP_RDATA and RSP_ERR are stable while waiting.
- **Lane enable masks**, with off = addr[1:0]:
  - byte: 1<<off.
  - half: 0011 if off=0, 1100 if off=2.
  - word: 1111.
  - Store → LANE_WE = mask, LANE_RE = 0. Load → LANE_RE = mask, LANE_WE = 0.
- **Store data replication:**
  - byte: WDATA[7:0] on all four lanes.
  - half: WDATA[15:0] on both halves.
  - word: WDATA as is.
- **Load extraction:**
  - byte: lane off, extended by bit 7 unless unsigned.
  - half: lanes off+1:off, extended by bit 15 unless unsigned.
  - word: all four lanes.
- LANE_ADDR = latched REQ_ADDR[ADDR_WIDTH-1:2]. Outside ACCESS it holds its last value; the enables are 0.
- Only one request is in flight; REQ_READY=0 outside IDLE.

## Timing
- Request accepted at edge E0 → ACCESS in cycle 1.
- Store: RSP_VALID from cycle 2. The RAM write occurs at the edge ending cycle 1.
- Load: RSP_VALID from cycle 3.
- Error: RSP_VALID from cycle 1, no lane activity at all.
- Response accepted at edge Ek → IDLE. The next request can be accepted at the edge after that (REQ_READY=1 in that cycle).
- Reset values: state IDLE; LANE_WE=0, LANE_RE=0, LANE_ADDR=0, LANE_DIN=0; RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0; REQ_READY=0 while RST=1.
- Reset mid-operation: the FSM returns to IDLE at the reset edge and any pending response is dropped.
  - Lane enables are 0 from the cycle after the reset edge.
  - A write already driven in ACCESS during the reset-edge cycle still commits, because the RAMs have no reset.
- REQ_VALID while busy is ignored (not latched). Inputs are sampled only at the accepting edge.

## Test plan
- **Word store/load.** Store 0xDEADBEEF at addr 0x10. Then load word 0x10.
  - Store: LANE_WE=1111 and LANE_ADDR=4 in cycle 1; RSP_VALID in cycle 2.
  - Load: RSP_RDATA=0xDEADBEEF, RSP_ERR=0, in cycle 3.
- **Byte sign/zero extension.** After the word store, load byte addr 0x13.
  - Signed → 0xFFFFFFDE.
  - Unsigned → 0x000000DE.
  - LANE_RE=1000 in both cases.
- **Half store and load.** Store half 0x8001 at 0x12.
  - LANE_WE=1100 and LANE_DIN=0x80018001.
  - A later word load of 0x10 → 0x8001BEEF.
  - A signed half load of 0x12 → 0xFFFF8001.
- **Misaligned and illegal requests.** Word at 0x11, half at 0x13, size 11 at 0x10.
  - Each gives RSP_ERR=1 and RSP_RDATA=0 in cycle 1.
  - LANE_WE and LANE_RE stay 0 throughout; memory contents are unchanged.
- **Backpressure.** Hold RSP_READY=0 for 5 cycles after a load.
  - RSP_VALID and RSP_RDATA stay stable; REQ_READY=0; a concurrent REQ_VALID is not accepted.
  - Release RSP_READY → IDLE next cycle.
- **Reset mid-load.** Assert RST in LOAD_WAIT.
  - Next cycle: RSP_VALID=0 and all lane enables 0.
  - After RST falls, REQ_READY=1 and a fresh load returns correct data.
